mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Iterative shift-add multiply controller for the MUL instruction path of the multicycle core.
- Takes SrcA/SrcB when the main FSM asserts Start during an opMul execute, steps one multiplier bit per cycle, and returns the low WIDTH bits of the product with a one-cycle Done pulse.
- Busy lets the main FSM hold in execute, so the single-cycle ALU never needs a combinational 32x32 multiplier.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CW, $clog2(WIDTH+1), width of the iteration counter and Count port.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  request a multiply; sampled only in IDLE
- SrcA  input  WIDTH  multiplicand (Rn), sampled with Start
- SrcB  input  WIDTH  multiplier (Rm), sampled with Start
- Result  output  WIDTH  product [WIDTH-1:0], registered
- Done  output  1  one-cycle pulse, Result and MulFlags valid
- Busy  output  1  high while state is RUN
- MulFlags  output  2  {N,Z} of Result, registered with Result
- Count  output  CW  iterations completed in the current or last operation

Behaviour:
- Reset: state=IDLE; Result=0, MulFlags=2'b01 (Z set, since Result=0), Done=0, Busy=0, Count=0. Internal mcand/mplier/acc cleared.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - Start=1 latches mcand=SrcA, mplier=SrcB, acc=0, Count=0, then moves to RUN.
  - Start=0 stays in IDLE.
  - Result and MulFlags hold their last values.
- RUN, each cycle:
  - If mplier[0]=1, acc = acc + mcand modulo 2^WIDTH (carry discarded).
  - mcand <<= 1 (bits shifted out are lost); mplier >>= 1 logically; Count++.
  - When Count reaches WIDTH after the increment, move to DONE.
  - Start is ignored in RUN; operands are never re-latched mid-operation.
- DONE (one cycle):
  - Result=acc; MulFlags[1]=acc[WIDTH-1], MulFlags[0]=(acc==0); Done=1.
  - Unconditional move to IDLE; Start in DONE is ignored and must be held or re-asserted in IDLE.
- Latency (full mode): Start sampled at edge 0, RUN covers edges 1..WIDTH, Done=1 in the cycle after edge WIDTH+1. For WIDTH=32, Done appears 33 cycles after Start, and back-to-back starts are spaced 34 cycles apart.
- Busy is a registered decode of state==RUN; it is 0 in IDLE and DONE.
- Done is exactly one cycle wide, never asserted outside DONE.
- Result is unsigned low-half product, which equals the signed low half; no C/V flags are produced.
- Reset mid-RUN or in DONE: next cycle is IDLE with reset values, and no Done pulse is emitted.
- Start and reset together: reset wins.
- SrcA/SrcB may change freely after the Start cycle.

Optional Feature:
- Macro: MUL_SEQ_EARLY_EXIT_EN.
- Defined: in RUN, if the shifted mplier equals 0 after the current step, move to DONE next regardless of Count. Count then reports the iterations actually performed (= bit position of the MSB of SrcB + 1; 1 when SrcB=0).
- Undefined: always WIDTH iterations, as described above.
- Result is identical in both modes.

Test Plan:
- Reset then idle 5 cycles: Result=0, MulFlags=01, Done=0, Busy=0, Count=0.
- SrcA=7, SrcB=6, Start one cycle: Busy for 32 cycles, Done on cycle 33, Result=42, MulFlags=00, Count=32. With MUL_SEQ_EARLY_EXIT_EN: Count=3, Done on cycle 4.
- SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF: Result=0x00000001, MulFlags=00. SrcA=0x80000000, SrcB=1: Result=0x80000000, MulFlags=10.
- SrcA=0x1234, SrcB=0: Result=0, MulFlags=01. Early-exit build: Count=1, Done on cycle 2.
- Start with 3*5, then Start with 9*9 at cycle 10 during RUN: second request ignored, Result=15. Start held high through DONE: next op begins in IDLE, Result=15 then 15 again.
- Reset at cycle 12 of a 3*5 run: no Done pulse, Result=0, IDLE next cycle. A fresh Start with 4*4 then gives Result=16.

Source files
------------

// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, low WIDTH bits of product.
// Optional MUL_SEQ_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             Busy,
    output logic [1:0]       MulFlags,
    output logic [CW-1:0]    Count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       flags_q, flags_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             last_step;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        result_d  = result_q;
        flags_d   = flags_q;
        done_d    = 1'b0;
        last_step = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    mcand_d  = SrcA;
                    mplier_d = SrcB;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
`ifdef MUL_SEQ_EARLY_EXIT_EN
                last_step = (count_d == LAST) || (mplier_d == '0);
`else
                last_step = (count_d == LAST);
`endif
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = acc_q;
                flags_d  = {acc_q[WIDTH-1], acc_q == '0};
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Busy is registered but decoded from the next state so it tracks state==RUN exactly.
        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            flags_q  <= 2'b01;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign Result   = result_q;
    assign Done     = done_q;
    assign Busy     = busy_q;
    assign MulFlags = flags_q;
    assign Count    = count_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: per-cycle comparison against a product/latency model
// plus directed operations with literal expectations.
module tb_mul_sequencer;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          Start;
    logic [W-1:0]  SrcA, SrcB;
    logic [W-1:0]  Result;
    logic          Done, Busy;
    logic [1:0]    MulFlags;
    logic [CW-1:0] Count;

    always #5 clk = ~clk;

    mul_sequencer #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Result   (Result),
        .Done     (Done),
        .Busy     (Busy),
        .MulFlags (MulFlags),
        .Count    (Count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Iterations an operation takes: every bit, or only up to the multiplier's MSB.
    function automatic int iters(input logic [W-1:0] b);
        int n;
        n = W;
        if (EE) begin
            n = 1;
            for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    // Model: what each output must be after every edge.
    bit           m_valid = 1'b0;
    bit           m_idle;
    int           m_phase, m_n;
    logic [W-1:0] m_prod;
    logic [W-1:0] e_result;
    logic [1:0]   e_flags;
    logic         e_done, e_busy;
    int           e_count;

    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            m_idle   = 1'b1;
            e_result = '0;
            e_flags  = 2'b01;
            e_done   = 1'b0;
            e_busy   = 1'b0;
            e_count  = 0;
        end else if (m_valid) begin
            e_done = 1'b0;
            if (m_idle) begin
                if (Start) begin
                    m_prod  = SrcA * SrcB;
                    m_n     = iters(SrcB);
                    m_phase = 0;
                    e_count = 0;
                    e_busy  = 1'b1;
                    m_idle  = 1'b0;
                end
            end else begin
                m_phase++;
                if (m_phase <= m_n) begin
                    e_count = m_phase;
                    e_busy  = (m_phase < m_n);
                end else begin
                    e_done   = 1'b1;
                    e_result = m_prod;
                    e_flags  = {m_prod[W-1], m_prod == '0};
                    m_idle   = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_result", Result, e_result);
            check("cyc_flags", W'(MulFlags), W'(e_flags));
            check("cyc_done", W'(Done), W'(e_done));
            check("cyc_busy", W'(Busy), W'(e_busy));
            check("cyc_count", W'(Count), W'(e_count));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!Done && n < 100);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_res, input logic [1:0] exp_flags,
                          input int exp_lat, input int exp_cnt);
        int n;
        @(negedge clk);
        SrcA  = a;
        SrcB  = b;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        SrcA  = $urandom;
        SrcB  = $urandom;
        wait_done(n);
        check({name, "_latency"}, W'(n), W'(exp_lat));
        check({name, "_result"}, Result, exp_res);
        check({name, "_flags"}, W'(MulFlags), W'(exp_flags));
        check({name, "_count"}, W'(Count), W'(exp_cnt));
    endtask

    initial begin
        int n;
        reset = 1'b1;
        Start = 1'b0;
        SrcA  = '0;
        SrcB  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_result", Result, 32'h0);
        check("rst_flags", W'(MulFlags), W'(2'b01));
        check("rst_done", W'(Done), W'(1'b0));
        check("rst_busy", W'(Busy), W'(1'b0));
        check("rst_count", W'(Count), W'(0));

        run_op("m7x6", 32'd7, 32'd6, 32'd42, 2'b00, EE ? 4 : 33, EE ? 3 : 32);
        run_op("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 33, 32);
        run_op("m80x1", 32'h8000_0000, 32'd1, 32'h8000_0000, 2'b10, EE ? 2 : 33, EE ? 1 : 32);
        run_op("m1234x0", 32'h1234, 32'd0, 32'd0, 2'b01, EE ? 2 : 33, EE ? 1 : 32);

        // Second Start during RUN must be ignored.
        @(negedge clk);
        SrcA  = 32'd3;
        SrcB  = 32'd5;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat ((EE ? 2 : 10) - 1) begin
            @(posedge clk);
            #1;
        end
        SrcA  = 32'd9;
        SrcB  = 32'd9;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_done(n);
        check("ign_result", Result, 32'd15);
        @(posedge clk);
        #1;
        check("ign_busy_after", W'(Busy), W'(1'b0));

        // Start held high through DONE: next operation only begins from IDLE.
        @(negedge clk);
        SrcA  = 32'd3;
        SrcB  = 32'd5;
        Start = 1'b1;
        wait_done(n);
        check("held_result1", Result, 32'd15);
        wait_done(n);
        Start = 1'b0;
        check("held_spacing", W'(n), W'(EE ? 5 : 34));
        check("held_result2", Result, 32'd15);
        repeat (3) @(negedge clk);

        // Reset in the middle of a run.
        @(negedge clk);
        SrcA  = 32'd3;
        SrcB  = 32'd5;
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (11) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("mid_rst_done", W'(Done), W'(1'b0));
        check("mid_rst_result", Result, 32'd0);
        check("mid_rst_busy", W'(Busy), W'(1'b0));
        check("mid_rst_count", W'(Count), W'(0));
        check("mid_rst_flags", W'(MulFlags), W'(2'b01));
        repeat (30) @(negedge clk);
        run_op("m4x4", 32'd4, 32'd4, 32'd16, 2'b00, EE ? 4 : 33, EE ? 3 : 32);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
